// File: rtl/button_pkg.sv
// Shared definitions for the push-button debouncer.
//   btn_state_e        : per-channel debounce state
//   BTN_PRESCALE       : default clk cycles per debounce tick (1 ms at 50 MHz)
//   BTN_DEBOUNCE_TICKS : default number of stable ticks needed to accept a change
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    ARM_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    ARM_RELEASE = 2'd3
  } btn_state_e;

  localparam int BTN_PRESCALE       = 50000;
  localparam int BTN_DEBOUNCE_TICKS = 20;

endpackage

// File: rtl/button_debouncer_if.sv
// Button bundle between the board pins, the debouncer and the button PIO.
//   btn_raw     : unsynchronized pin levels
//   btn_level   : debounced state, 1 = pressed
//   btn_press   : 1-cycle pulse on an accepted press
//   btn_release : 1-cycle pulse on an accepted release
// The debouncer uses the slave view; the pin/PIO side uses the master view.
interface button_debouncer_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] btn_raw;
  logic [WIDTH-1:0] btn_level;
  logic [WIDTH-1:0] btn_press;
  logic [WIDTH-1:0] btn_release;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release
  );

endinterface

// File: rtl/button_debounce_channel.sv
// One button channel: 2-FF synchronizer followed by a tick-based debounce FSM.
//   clk, reset_n : system clock, asynchronous active-low reset
//   tick         : shared prescaler strobe, one debounce step per pulse
//   btn_raw      : unsynchronized pin
//   btn_level    : debounced state, 1 = pressed (registered)
//   btn_press    : 1-cycle pulse in the cycle btn_level rises (registered)
//   btn_release  : 1-cycle pulse in the cycle btn_level falls (registered)
module button_debounce_channel
  import button_pkg::*;
#(
  parameter int ACTIVE_LOW     = 1,
  parameter int DEBOUNCE_TICKS = BTN_DEBOUNCE_TICKS
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int              CW       = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic            IDLE_PIN = (ACTIVE_LOW != 0);
  localparam logic [CW-1:0]   CNT_DONE = CW'(DEBOUNCE_TICKS);

  logic [1:0]    sync_q;
  logic          pressed_s;
  btn_state_e    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  // NOTE: the synchronizer resets to the idle pin level, not to 0, so a
  // released ACTIVE_LOW button does not look pressed right after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {2{IDLE_PIN}};
    end else begin
      sync_q <= {sync_q[0], btn_raw};
    end
  end

  assign pressed_s = sync_q[1] ^ IDLE_PIN;

  // Saturating increment: the counter can never wrap past DEBOUNCE_TICKS.
  assign cnt_inc = (cnt == CNT_DONE) ? cnt : cnt + 1'b1;

  // NOTE: all state and outputs use non-blocking assignments so every
  // register samples the pre-edge values; pulses default low each cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RELEASED;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      case (state)
        RELEASED: begin
          if (pressed_s) begin
            state <= ARM_PRESS;
            cnt   <= '0;
          end
        end
        ARM_PRESS: begin
          // A bounce back wins over a tick arriving in the same cycle.
          if (!pressed_s) begin
            state <= RELEASED;
          end else if (tick) begin
            cnt <= cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              state     <= PRESSED;
              btn_level <= 1'b1;
              btn_press <= 1'b1;
            end
          end
        end
        PRESSED: begin
          if (!pressed_s) begin
            state <= ARM_RELEASE;
            cnt   <= '0;
          end
        end
        ARM_RELEASE: begin
          if (pressed_s) begin
            state <= PRESSED;
          end else if (tick) begin
            cnt <= cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              state       <= RELEASED;
              btn_level   <= 1'b0;
              btn_release <= 1'b1;
            end
          end
        end
        default: begin
          state     <= RELEASED;
          cnt       <= '0;
          btn_level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Debounces WIDTH raw push-button pins for the button PIO.
//   clk, reset_n : system clock, asynchronous active-low reset
//   btn          : slave view of the button bundle (raw pins in, clean
//                  level plus press/release pulses out)
// One shared prescaler produces the debounce tick; each channel is an
// independent synchronizer + debounce FSM.
module button_debouncer
  import button_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int ACTIVE_LOW     = 1,
  parameter int PRESCALE       = BTN_PRESCALE,
  parameter int DEBOUNCE_TICKS = BTN_DEBOUNCE_TICKS
) (
  input  logic                clk,
  input  logic                reset_n,
  button_debouncer_if.slave   btn
);

  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt;
  logic          tick;

  // With PRESCALE=1 the counter stays at 0 and tick is high every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  assign tick = (pre_cnt == PRE_LAST);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    button_debounce_channel #(
      .ACTIVE_LOW     (ACTIVE_LOW),
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_chan (
      .clk         (clk),
      .reset_n     (reset_n),
      .tick        (tick),
      .btn_raw     (btn.btn_raw[i]),
      .btn_level   (btn.btn_level[i]),
      .btn_press   (btn.btn_press[i]),
      .btn_release (btn.btn_release[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer.
// Main DUT: PRESCALE=1, DEBOUNCE_TICKS=8, ACTIVE_LOW=1, WIDTH=4, compared every
// cycle against a sliding-window reference model. Second DUT: PRESCALE=4,
// checked for press/release latency window.
module tb_button_debouncer;

  localparam int W    = 4;
  localparam int D    = 8;
  localparam int HLEN = D + 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  button_debouncer_if #(.WIDTH(W)) bif  ();
  button_debouncer_if #(.WIDTH(W)) bif4 ();

  button_debouncer #(
    .WIDTH(W), .ACTIVE_LOW(1), .PRESCALE(1), .DEBOUNCE_TICKS(D)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (bif)
  );

  button_debouncer #(
    .WIDTH(W), .ACTIVE_LOW(1), .PRESCALE(4), .DEBOUNCE_TICKS(D)
  ) dut4 (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (bif4)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: a change is accepted at the clock edge where the
  // synchronized "pressed" value has disagreed with the debounced level on
  // D+1 consecutive edges. The FSM sees the pin as sampled two edges earlier.
  // hist[ch][k] = pressed value sampled k+1 edges ago.
  bit          hist [W][HLEN];
  logic [W-1:0] m_level, m_press, m_release;

  always @(posedge clk or negedge reset_n) begin : model
    bit all_diff;
    if (!reset_n) begin
      for (int ch = 0; ch < W; ch++)
        for (int k = 0; k < HLEN; k++) hist[ch][k] = 1'b0;
      m_level   = '0;
      m_press   = '0;
      m_release = '0;
    end else begin
      for (int ch = 0; ch < W; ch++) begin
        all_diff = 1'b1;
        for (int k = 1; k <= D + 1; k++)
          if (hist[ch][k] == m_level[ch]) all_diff = 1'b0;
        m_press[ch]   = all_diff && !m_level[ch];
        m_release[ch] = all_diff &&  m_level[ch];
        if (all_diff) m_level[ch] = ~m_level[ch];
        for (int k = HLEN - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
        hist[ch][0] = ~bif.btn_raw[ch];
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("model_level",   bif.btn_level,   m_level);
      check("model_press",   bif.btn_press,   m_press);
      check("model_release", bif.btn_release, m_release);
    end
  end

  int hold [W];
  int lat;

  initial begin
    bif.btn_raw  = '1;
    bif4.btn_raw = '1;
    reset_n      = 1'b0;
    wait_cyc(3);
    #2 reset_n = 1'b1;

    // 1: idle after reset
    wait_cyc(50);
    check("t1_level",   bif.btn_level,   4'h0);
    check("t1_press",   bif.btn_press,   4'h0);
    check("t1_release", bif.btn_release, 4'h0);

    // 2: clean press on channel 0, sampled at edge C
    bif.btn_raw[0] = 1'b0;
    wait_cyc(10);
    check("t2_level_before", bif.btn_level[0], 1'b0);
    wait_cyc(1);
    check("t2_level", bif.btn_level[0], 1'b1);
    check("t2_press", bif.btn_press[0], 1'b1);
    wait_cyc(1);
    check("t2_press_gone", bif.btn_press[0], 1'b0);
    wait_cyc(5);

    // 3: short glitch on channel 1 is rejected
    bif.btn_raw[1] = 1'b0;
    wait_cyc(5);
    bif.btn_raw[1] = 1'b1;
    wait_cyc(20);
    check("t3_level", bif.btn_level[1], 1'b0);

    // 4: release with chatter on channel 0
    bif.btn_raw[0] = 1'b1; wait_cyc(1);
    bif.btn_raw[0] = 1'b0; wait_cyc(1);
    bif.btn_raw[0] = 1'b1; wait_cyc(1);
    bif.btn_raw[0] = 1'b0; wait_cyc(1);
    bif.btn_raw[0] = 1'b1;
    wait_cyc(10);
    check("t4_level_held",   bif.btn_level[0],   1'b1);
    check("t4_release_early", bif.btn_release[0], 1'b0);
    wait_cyc(1);
    check("t4_release", bif.btn_release[0], 1'b1);
    check("t4_level",   bif.btn_level[0],   1'b0);
    wait_cyc(1);
    check("t4_release_gone", bif.btn_release[0], 1'b0);
    wait_cyc(10);

    // 5: all channels pressed together
    bif.btn_raw = '0;
    wait_cyc(10);
    check("t5_press_early", bif.btn_press, 4'h0);
    wait_cyc(1);
    check("t5_press", bif.btn_press, 4'hF);
    check("t5_level", bif.btn_level, 4'hF);
    wait_cyc(1);
    check("t5_press_gone", bif.btn_press, 4'h0);
    bif.btn_raw = '1;
    wait_cyc(20);
    check("t5_level_off", bif.btn_level, 4'h0);

    // 6: reset in the middle of a press debounce on channel 2
    bif.btn_raw[2] = 1'b0;
    wait_cyc(5);
    #2 reset_n = 1'b0;
    #1;
    check("t6_level_rst",   bif.btn_level,   4'h0);
    check("t6_press_rst",   bif.btn_press,   4'h0);
    check("t6_release_rst", bif.btn_release, 4'h0);
    wait_cyc(3);
    #2 reset_n = 1'b1;
    wait_cyc(10);
    check("t6_press_early", bif.btn_press[2], 1'b0);
    wait_cyc(1);
    check("t6_press", bif.btn_press[2], 1'b1);
    check("t6_level", bif.btn_level[2], 1'b1);
    bif.btn_raw = '1;
    wait_cyc(20);

    // Random bouncing on all channels, checked cycle by cycle by the model
    for (int ch = 0; ch < W; ch++) hold[ch] = 1;
    repeat (2000) begin
      for (int ch = 0; ch < W; ch++) begin
        hold[ch]--;
        if (hold[ch] == 0) begin
          bif.btn_raw[ch] = ~bif.btn_raw[ch];
          hold[ch] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4))
                                                  : int'($urandom_range(5, 20));
        end
      end
      wait_cyc(1);
    end
    bif.btn_raw = '1;
    wait_cyc(20);
    check("rand_idle_level", bif.btn_level, 4'h0);

    // PRESCALE=4: latency from pin sample edge lies within [31, 34] edges
    for (int rep = 0; rep < 4; rep++) begin
      wait_cyc(int'($urandom_range(0, 7)));
      bif4.btn_raw[0] = 1'b0;
      lat = -1;
      for (int k = 1; k <= 60; k++) begin
        wait_cyc(1);
        if (bif4.btn_level[0] === 1'b1) begin
          lat = k - 1;
          check("p4_press_pulse", bif4.btn_press[0], 1'b1);
          break;
        end
      end
      check($sformatf("p4_press_lat_%0d_in_31_34", lat), (lat >= 31 && lat <= 34), 1'b1);
      wait_cyc(int'($urandom_range(0, 7)));
      bif4.btn_raw[0] = 1'b1;
      lat = -1;
      for (int k = 1; k <= 60; k++) begin
        wait_cyc(1);
        if (bif4.btn_level[0] === 1'b0) begin
          lat = k - 1;
          check("p4_release_pulse", bif4.btn_release[0], 1'b1);
          break;
        end
      end
      check($sformatf("p4_release_lat_%0d_in_31_34", lat), (lat >= 31 && lat <= 34), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
